muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide execution unit in the EX stage.
- Consumes the 8-bit alucontrol code produced by the ALU-control decoder and executes the HI/LO-writing ops: MULT, MULTU, DIV, DIVU.
- Produces a 64-bit {hi, lo} result and a stall request that freezes the pipeline while the operation runs.
- A flush input cancels an in-flight operation on exception or branch flush.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 113 +++++++++++
 tb/tb_muldiv_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the EX stage and the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [7:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  modport master (
    output start, alucontrol, a, b, annul,
    input  stall_req, busy, done, hi, lo, div_by_zero
  );
  modport slave (
    input  start, alucontrol, a, b, annul,
    output stall_req, busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned shift-add multiply and restoring divide into {hi, lo}
module muldiv_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [7:0] OP_MULT  = 8'b00011000,
  parameter logic [7:0] OP_MULTU = 8'b00011001,
  parameter logic [7:0] OP_DIV   = 8'b00011010,
  parameter logic [7:0] OP_DIVU  = 8'b00011011
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_it, prod;
  logic [2*WIDTH:0]   sh;
  logic [WIDTH:0]     sum, trial;
  logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic               mul_q, mul_d, neg_q, neg_d, nega_q, nega_d, dbz_q, dbz_d;
  logic               is_mul, is_div, sgn, accept, dz;
  assign is_mul = bus.alucontrol == OP_MULT || bus.alucontrol == OP_MULTU;
  assign is_div = bus.alucontrol == OP_DIV || bus.alucontrol == OP_DIVU;
  assign sgn    = bus.alucontrol == OP_MULT || bus.alucontrol == OP_DIV;
  assign accept = bus.start && state_q == IDLE && !bus.annul && (is_mul || is_div);
  assign dz     = is_div && bus.b == '0;
  assign a_mag  = sgn && bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag  = sgn && bus.b[WIDTH-1] ? -bus.b : bus.b;
  // One iteration: multiply adds the multiplicand and shifts right; divide shifts left and trial-subtracts
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    sh     = {acc_q, 1'b0};
    trial  = sh[2*WIDTH:WIDTH] - {1'b0, m_q};
    acc_it = mul_q ? {sum, acc_q[WIDTH-1:1]} : trial[WIDTH] ? sh[2*WIDTH-1:0] : {trial[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
  end
  assign prod = neg_q ? -acc_it : acc_it;
  assign quo  = neg_q ? -acc_it[WIDTH-1:0] : acc_it[WIDTH-1:0];
  assign rem  = nega_q ? -acc_it[2*WIDTH-1:WIDTH] : acc_it[2*WIDTH-1:WIDTH];
  // Next-state: accept and latch magnitudes, iterate, commit the sign-fixed result on the last step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    nega_d  = nega_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (accept) begin
        mul_d   = is_mul;
        neg_d   = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        nega_d  = sgn && bus.a[WIDTH-1];
        m_d     = is_mul ? a_mag : b_mag;
        acc_d   = {{WIDTH{1'b0}}, is_mul ? b_mag : a_mag};
        cnt_d   = '0;
        state_d = dz ? DONE : BUSY;
        if (dz) begin
          hi_d  = bus.a;
          lo_d  = '1;
          dbz_d = 1'b1;
        end
      end
      BUSY: begin
        acc_d = acc_it;
        cnt_d = cnt_q + 1'b1;
        if (bus.annul) state_d = IDLE;
        else if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          hi_d    = mul_q ? prod[2*WIDTH-1:WIDTH] : rem;
          lo_d    = mul_q ? prod[WIDTH-1:0] : quo;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      nega_q  <= nega_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end
  assign bus.stall_req   = accept || state_q == BUSY;
  assign bus.busy        = state_q == BUSY;
  assign bus.done        = state_q == DONE;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a 64-bit arithmetic model
module tb_muldiv_unit;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_ADD   = 8'b00100000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          nvec = 0;
  int          nerr = 0;
  logic [64:0] last = '0;
  logic [7:0]  ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  // {div_by_zero, hi, lo} from plain 64-bit arithmetic; longint division truncates toward zero
  function automatic logic [64:0] model(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == OP_MULT) return {1'b0, 64'(sx * sy)};
    if (op == OP_MULTU) return {1'b0, {32'b0, x} * {32'b0, y}};
    if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
    if (op == OP_DIVU) return {1'b0, x % y, x / y};
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[31:0], q[31:0]};
  endfunction
  task automatic do_op(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] e;
    int lat, stalls, busys, n;
    e = model(op, x, y);
    n = e[64] ? 1 : 33;
    bus.start = 1'b1;
    bus.alucontrol = op;
    bus.a = x;
    bus.b = y;
    #1 check("issue_stall", 65'(bus.stall_req), 65'd1);
    tick();
    bus.start = 1'b0;
    bus.alucontrol = 8'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 1;
    stalls = 1;
    busys = 0;
    while (!bus.done && lat < 60) begin
      stalls += int'(bus.stall_req);
      busys += int'(bus.busy);
      bus.start = lat inside {[3:6]};
      bus.alucontrol = OP_DIVU;
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check("latency", 65'(lat), 65'(n));
    check("stall_cycles", 65'(stalls), 65'(n));
    check("busy_cycles", 65'(busys), 65'(n - 1));
    check("done_stall", 65'(bus.stall_req), 65'd0);
    check("result", {bus.div_by_zero, bus.hi, bus.lo}, e);
    tick();
    check("done_pulse", 65'(bus.done), 65'd0);
    check("hold", {bus.div_by_zero, bus.hi, bus.lo}, e);
    last = e;
  endtask
  initial begin
    int n;
    bus.start = 1'b0;
    bus.alucontrol = '0;
    bus.a = '0;
    bus.b = '0;
    bus.annul = 1'b0;
    repeat (2) tick();
    check("reset_state", {bus.busy, bus.done, bus.stall_req, bus.div_by_zero, bus.hi, bus.lo}, 65'd0);
    rst = 1'b0;
    tick();
    do_op(OP_DIVU, 100, 7);
    do_op(OP_DIV, 32'hFFFFFFF9, 2);
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    do_op(OP_MULT, 32'hFFFFFFFE, 3);
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(OP_DIVU, 5, 0);
    do_op(OP_MULTU, 3, 4);
    bus.start = 1'b1;
    bus.alucontrol = OP_ADD;
    bus.a = $urandom;
    bus.b = $urandom;
    #1 check("ignore_stall", 65'(bus.stall_req), 65'd0);
    tick();
    check("ignore_state", {bus.busy, bus.done}, 65'd0);
    bus.alucontrol = OP_MULT;
    bus.annul = 1'b1;
    #1 check("annul_idle_stall", 65'(bus.stall_req), 65'd0);
    tick();
    check("annul_idle_state", {bus.busy, bus.done}, 65'd0);
    bus.annul = 1'b0;
    bus.alucontrol = OP_DIV;
    bus.b = $urandom | 1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.annul = 1'b1;
    #1 check("annul_busy_stall", 65'(bus.stall_req), 65'd1);
    tick();
    bus.annul = 1'b0;
    check("annul_to_idle", {bus.busy, bus.stall_req}, 65'd0);
    n = 0;
    repeat (40) begin
      n += int'(bus.done);
      tick();
    end
    check("annul_no_done", 65'(n), 65'd0);
    check("annul_keep", {bus.div_by_zero, bus.hi, bus.lo}, last);
    bus.start = 1'b1;
    bus.alucontrol = OP_MULTU;
    bus.a = $urandom | 32'h80000000;
    bus.b = $urandom | 32'h80000000;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    check("mid_reset", {bus.busy, bus.done, bus.stall_req, bus.div_by_zero, bus.hi, bus.lo}, 65'd0);
    rst = 1'b0;
    do_op(OP_DIVU, 1000, 33);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: x = 32'h80000000;
        2: y = 32'hFFFFFFFF;
        3: y = $urandom_range(1, 15);
        default: ;
      endcase
      do_op(ops[$urandom_range(0, 3)], x, y);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
